priority_encoder_8to3_hs: RTL and testbench
===========================================

// Module: priority_encoder_8to3_hs
// PURPOSE
//  Inverse of the 3-to-8 active-low decoder. Captures 8 active-low request lines, queues
//  them as pending, and hands one at a time to a consumer as a 3-bit index {A,B,C}.
//  The consumer uses a valid/ack handshake. Sits ahead of the decoder or a dispatcher.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer flops on req_n (legal 1..3)
//  RR_MODE      0  0 = fixed priority, bit 7 highest; 1 = round-robin after the last grant
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous, active-low reset
//  en       in   1  active-high enable for capture and new grants
//  req_n    in   8  asynchronous request lines, active low; req_n[i]=0 requests index i
//  ack      in   1  consumer accepts the current index; sampled only while valid=1
//  clr_ovf  in   1  synchronous clear of ovf
//  A,B,C    out  1  granted index, A=MSB; registered; stable while valid=1
//  valid    out  1  index is valid
//  pending  out  8  pending request bits
//  pend_n   out  1  active low; 0 when any pending bit is 1
//  ovf      out  1  sticky: a request was lost
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs go low immediately except pend_n=1.
//   - pending=0, valid=0, {A,B,C}=000, ovf=0, sync/prev flops=0 (req deasserted),
//     state=IDLE, last_idx=7.
//  Capture:
//   - req = ~req_n, passed through SYNC_STAGES flops to give req_s; prev holds the last req_s.
//   - Edge on bit i: req_s[i] & ~prev[i]. A held-low line counts once.
//   - If en=1, an edge sets pending[i] at the next clk edge.
//   - Latency from a req_n fall to pending set is SYNC_STAGES+1 edges.
//   - If en=0, edges are dropped and pending is unchanged.
//  FSM has 2 states:
//   - IDLE: if en & |pending, pick index sel; register {A,B,C}=sel, valid=1, go to GRANT.
//     Latency from a req_n fall to valid=1 is SYNC_STAGES+2 edges.
//   - GRANT: hold valid and index, ignoring en. On ack=1: clear pending[idx],
//     last_idx=idx, valid=0 on the same edge, go to IDLE.
//     There is a minimum one-cycle gap between grants.
//  Selection:
//   - RR_MODE=0: highest set pending bit.
//   - RR_MODE=1: first set bit scanning last_idx+1, +2, ... with 7 wrapping to 0.
//   - Selection is evaluated only in IDLE. New arrivals during GRANT never change the
//     current index.
//  Simultaneous events:
//   - Edge on bit i in the same cycle as the ack clear of i: set wins, pending[i]=1, no ovf.
//   - Edge on a bit already pending and not being cleared: the bit stays 1 and ovf=1.
//   - clr_ovf and a new overflow in the same cycle: ovf=1, set wins.
//  pend_n = ~|pending (registered-logic output, combinational from pending).
//  ack while valid=0 is ignored.
//  Reset mid-GRANT aborts the grant. No ack is owed after reset.
// TESTING
//  1. Request from bit 4:
//     - Stimulus: reset, en=1, req_n=8'hEF for 1 cycle, then FF.
//     - Required: pending=8'h10 at edge 3; valid=1, ABC=100 at edge 4.
//     - Then ack=1 one cycle -> valid=0, pending=0, pend_n=1.
//  2. Fixed priority:
//     - Stimulus: req_n=8'b1001_1101 pulse, ack in each GRANT.
//     - Required: grants 110, 101, 001 in order, each separated by one IDLE cycle.
//  3. Round-robin (RR_MODE=1):
//     - Stimulus: pulse bits 0,3,7, then acks.
//     - Required: grants 000, 011, 111.
//     - Then pulse bits 3,5 with last_idx=7 -> grants 011, 101.
//  4. Overflow:
//     - Stimulus: pulse bit 2 twice before ack.
//     - Required: ovf=1 and pending[2]=1; a single grant of 010.
//     - Then clr_ovf=1 -> ovf=0.
//  5. Enable low:
//     - Stimulus: en=0 while req pulses arrive.
//     - Required: pending unchanged. A GRANT already active stays valid and completes on ack.
//     - No new grant issues until en=1.
//  6. Reset mid-GRANT:
//     - Stimulus: valid=1, then drop rst_n between clock edges.
//     - Required: valid=0, ABC=000, pending=0, pend_n=1 immediately.
//     - After release, the next grant needs a fresh request.

Source files
------------

// File: rtl/priority_encoder_8to3_hs_if.sv
// Consumer-side bundle of the 8-to-3 priority encoder: request capture, handshake and status.
// The master modport is the block that raises requests and consumes indices; the slave is the encoder.
interface priority_encoder_8to3_hs_if;
    logic       en;
    logic [7:0] req_n;
    logic       ack;
    logic       clr_ovf;
    logic       A;
    logic       B;
    logic       C;
    logic       valid;
    logic [7:0] pending;
    logic       pend_n;
    logic       ovf;

    modport master (
        output en, req_n, ack, clr_ovf,
        input  A, B, C, valid, pending, pend_n, ovf
    );

    modport slave (
        input  en, req_n, ack, clr_ovf,
        output A, B, C, valid, pending, pend_n, ovf
    );
endinterface

// File: rtl/priority_encoder_8to3_hs.sv
// Captures active-low request edges into a pending set and grants one index at a time
// over a valid/ack handshake, with fixed-priority or round-robin selection.
module priority_encoder_8to3_hs #(
    parameter int SYNC_STAGES = 2,
    parameter bit RR_MODE     = 1'b0
) (
    input logic                          clk,
    input logic                          rst_n,
    priority_encoder_8to3_hs_if.slave    bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] req_s;
    logic [7:0] prev;
    logic [7:0] edges;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic [7:0] pending;
    logic [2:0] idx;
    logic [2:0] last_idx;
    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;
    logic       valid;
    logic       ovf;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign edges    = req_s & ~prev;
    assign set_mask = bus.en ? edges : 8'h00;
    assign clr_mask = (state == GRANT && bus.ack) ? (8'h01 << idx) : 8'h00;

    // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
    always_comb begin
        sel   = 3'd0;
        cand  = 3'd0;
        found = 1'b0;
        if (RR_MODE) begin
            for (int k = 1; k <= 8; k++) begin
                cand = last_idx + 3'(k);
                if (!found && pending[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) sel = 3'(i);
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchronizer array is reset so every line reads as deasserted after reset.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 8'h00;
            prev     <= 8'h00;
            pending  <= 8'h00;
            ovf      <= 1'b0;
            state    <= IDLE;
            valid    <= 1'b0;
            idx      <= 3'd0;
            last_idx <= 3'd7;
        end else begin
            sync_q[0] <= ~bus.req_n;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev    <= req_s;
            // A set landing on the bit being acked re-arms it rather than counting as a loss.
            pending <= (pending & ~clr_mask) | set_mask;
            if (|(set_mask & pending & ~clr_mask)) ovf <= 1'b1;
            else if (bus.clr_ovf)                  ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.en && |pending) begin
                        idx   <= sel;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        valid    <= 1'b0;
                        last_idx <= idx;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A       = idx[2];
    assign bus.B       = idx[1];
    assign bus.C       = idx[0];
    assign bus.valid   = valid;
    assign bus.pending = pending;
    assign bus.pend_n  = ~|pending;
    assign bus.ovf     = ovf;

endmodule

// File: tb/tb_priority_encoder_8to3_hs.sv
// Drives a fixed-priority and a round-robin encoder with shared requests; a consumer
// process acks each grant and compares its index against a per-instance expectation queue.
module tb_priority_encoder_8to3_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr_ovf;
    logic       hold;
    logic [7:0] req_n;
    logic       ack [2];

    int n_pass   = 0;
    int n_checks = 0;

    logic [2:0] exp_q0 [$];
    logic [2:0] exp_q1 [$];
    logic       granted [2];
    logic [2:0] cur_idx [2];

    logic       valid_o  [2];
    logic [2:0] idx_o    [2];
    logic [7:0] pend_o   [2];
    logic       pend_n_o [2];
    logic       ovf_o    [2];

    priority_encoder_8to3_hs_if bus_fp ();
    priority_encoder_8to3_hs_if bus_rr ();

    priority_encoder_8to3_hs #(.SYNC_STAGES(2), .RR_MODE(1'b0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    priority_encoder_8to3_hs #(.SYNC_STAGES(2), .RR_MODE(1'b1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr)
    );

    always #5 clk = ~clk;

    assign bus_fp.en      = en;
    assign bus_fp.req_n   = req_n;
    assign bus_fp.clr_ovf = clr_ovf;
    assign bus_fp.ack     = ack[0];
    assign bus_rr.en      = en;
    assign bus_rr.req_n   = req_n;
    assign bus_rr.clr_ovf = clr_ovf;
    assign bus_rr.ack     = ack[1];

    assign valid_o[0]  = bus_fp.valid;
    assign idx_o[0]    = {bus_fp.A, bus_fp.B, bus_fp.C};
    assign pend_o[0]   = bus_fp.pending;
    assign pend_n_o[0] = bus_fp.pend_n;
    assign ovf_o[0]    = bus_fp.ovf;
    assign valid_o[1]  = bus_rr.valid;
    assign idx_o[1]    = {bus_rr.A, bus_rr.B, bus_rr.C};
    assign pend_o[1]   = bus_rr.pending;
    assign pend_n_o[1] = bus_rr.pend_n;
    assign ovf_o[1]    = bus_rr.ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag, input logic [7:0] pend, input logic vld, input logic ov);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_pending%0d", tag, i), 32'(pend_o[i]), 32'(pend));
            check($sformatf("%s_pend_n%0d", tag, i), 32'(pend_n_o[i]), 32'(pend == 8'h00));
            check($sformatf("%s_valid%0d", tag, i), 32'(valid_o[i]), 32'(vld));
            check($sformatf("%s_ovf%0d", tag, i), 32'(ovf_o[i]), 32'(ov));
        end
    endtask

    task automatic expect_grant(input logic [2:0] fp, input logic [2:0] rr);
        exp_q0.push_back(fp);
        exp_q1.push_back(rr);
    endtask

    task automatic take(input int i, output bit ok, output logic [2:0] e);
        ok = 1'b0;
        e  = 3'd0;
        if (i == 0 && exp_q0.size() != 0) begin ok = 1'b1; e = exp_q0.pop_front(); end
        if (i == 1 && exp_q1.size() != 0) begin ok = 1'b1; e = exp_q1.pop_front(); end
    endtask

    // Consumer: pops the expected index on each new grant, acks unless held.
    initial begin
        bit         ok;
        logic [2:0] e;
        for (int i = 0; i < 2; i++) begin
            ack[i]     = 1'b0;
            granted[i] = 1'b0;
            cur_idx[i] = 3'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    ack[i]     = 1'b0;
                    granted[i] = 1'b0;
                end else if (ack[i]) begin
                    ack[i]     = 1'b0;
                    granted[i] = 1'b0;
                    check($sformatf("valid_drop%0d", i), 32'(valid_o[i]), 32'd0);
                end else if (valid_o[i]) begin
                    if (!granted[i]) begin
                        granted[i] = 1'b1;
                        cur_idx[i] = idx_o[i];
                        take(i, ok, e);
                        if (ok) check($sformatf("grant_idx%0d", i), 32'(idx_o[i]), 32'(e));
                        else    check($sformatf("spurious_grant%0d", i), 32'(valid_o[i]), 32'd0);
                    end else begin
                        check($sformatf("idx_stable%0d", i), 32'(idx_o[i]), 32'(cur_idx[i]));
                    end
                    if (!hold) ack[i] = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        req_n   = 8'hFF;
        clr_ovf = 1'b0;
        hold    = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_state("reset", 8'h00, 1'b0, 1'b0);
        check("reset_idx_fp", 32'(idx_o[0]), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] m);
        @(posedge clk); #1 req_n = ~m;
        @(posedge clk); #1 req_n = 8'hFF;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || granted[0] || granted[1]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drain"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // 1: single request from bit 4, cycle-exact latency
        do_reset();
        expect_grant(3'd4, 3'd4);
        @(posedge clk); #1 req_n = 8'hEF;
        @(posedge clk); #1 req_n = 8'hFF;
        @(posedge clk); #1 check_state("t1_edge2", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1 check_state("t1_edge3", 8'h10, 1'b0, 1'b0);
        @(posedge clk); #1 check_state("t1_edge4", 8'h10, 1'b1, 1'b0);
        check("t1_idx_fp", 32'(idx_o[0]), 32'd4);
        drain("t1");
        check_state("t1_done", 8'h00, 1'b0, 1'b0);

        // 2: bits 6,5,1 together
        do_reset();
        expect_grant(3'd6, 3'd1);
        expect_grant(3'd5, 3'd5);
        expect_grant(3'd1, 3'd6);
        pulse(8'b0110_0010);
        drain("t2");
        check_state("t2_done", 8'h00, 1'b0, 1'b0);

        // 3: bits 0,3,7 then 3,5 continuing from last_idx=7
        do_reset();
        expect_grant(3'd7, 3'd0);
        expect_grant(3'd3, 3'd3);
        expect_grant(3'd0, 3'd7);
        pulse(8'b1000_1001);
        drain("t3a");
        expect_grant(3'd5, 3'd3);
        expect_grant(3'd3, 3'd5);
        pulse(8'b0010_1000);
        drain("t3b");

        // 4a: a new edge on bit 3 on the same edge its ack clears it
        do_reset();
        hold = 1'b1;
        expect_grant(3'd3, 3'd3);
        pulse(8'h08);
        repeat (4) @(posedge clk);
        @(posedge clk); #1 req_n = 8'hF7;
        @(posedge clk); #1 req_n = 8'hFF;
        @(posedge clk); #1 hold = 1'b0;
        @(posedge clk); #1 check_state("t4a_setwins", 8'h08, 1'b0, 1'b0);
        expect_grant(3'd3, 3'd3);
        drain("t4a");

        // 4b: bit 2 pulsed twice before ack, then clear, then clear colliding with a loss
        do_reset();
        hold = 1'b1;
        expect_grant(3'd2, 3'd2);
        pulse(8'h04);
        repeat (4) @(posedge clk);
        #1 check_state("t4b_first", 8'h04, 1'b1, 1'b0);
        pulse(8'h04);
        repeat (4) @(posedge clk);
        #1 check_state("t4b_ovf", 8'h04, 1'b1, 1'b1);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        check_state("t4b_clr", 8'h04, 1'b1, 1'b0);
        @(posedge clk); #1 req_n = 8'hFB;
        @(posedge clk); #1 req_n = 8'hFF;
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        check_state("t4b_clr_vs_set", 8'h04, 1'b1, 1'b1);
        hold = 1'b0;
        drain("t4b");
        repeat (6) @(negedge clk);
        check_state("t4b_single", 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        check_state("t4b_final_clr", 8'h00, 1'b0, 1'b0);

        // 5: enable low during an active grant
        do_reset();
        hold = 1'b1;
        expect_grant(3'd1, 3'd1);
        pulse(8'h02);
        repeat (4) @(posedge clk);
        pulse(8'h10);
        repeat (4) @(posedge clk);
        #1 check_state("t5_queued", 8'h12, 1'b1, 1'b0);
        en = 1'b0;
        pulse(8'h40);
        repeat (4) @(posedge clk);
        #1 check_state("t5_en_low", 8'h12, 1'b1, 1'b0);
        hold = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_state("t5_no_grant", 8'h10, 1'b0, 1'b0);
        expect_grant(3'd4, 3'd4);
        en = 1'b1;
        drain("t5");
        check_state("t5_done", 8'h00, 1'b0, 1'b0);

        // 6: reset dropped between edges while a grant is held
        do_reset();
        hold = 1'b1;
        expect_grant(3'd5, 3'd5);
        pulse(8'h20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_state("t6_async", 8'h00, 1'b0, 1'b0);
        check("t6_idx_fp", 32'(idx_o[0]), 32'd0);
        check("t6_idx_rr", 32'(idx_o[1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        repeat (8) @(negedge clk);
        check_state("t6_quiet", 8'h00, 1'b0, 1'b0);
        expect_grant(3'd5, 3'd5);
        pulse(8'h20);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
